// File: rtl/tmds_pattern_scheduler.sv
// Frame-synchronous test-pattern source for the three TMDS encoder lanes.
// Cycles five patterns at frame starts and emits registered RGB with timing delayed to match.
module tmds_pattern_scheduler #(
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int HOLD_FRAMES = 120
) (
  input  logic       pixel_clk,
  input  logic       rst,
  input  logic       active,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       fsync,
  input  logic       pause,
  input  logic       step,
  output logic [7:0] pdata_r,
  output logic [7:0] pdata_g,
  output logic [7:0] pdata_b,
  output logic       active_d,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic [2:0] pattern_id,
  output logic       pattern_chg,
  output logic       state_dbg
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int XW    = ($clog2(H_ACTIVE) > 6) ? $clog2(H_ACTIVE) : 6;
  localparam int YW    = ($clog2(V_ACTIVE) > 6) ? $clog2(V_ACTIVE) : 6;
  localparam int BW    = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;
  localparam int FW    = ($clog2(HOLD_FRAMES) > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [BW-1:0]   bar_cnt;
  logic [2:0]      bar_idx;
  logic [FW-1:0]   frame_cnt;
  logic            pending;
  logic            take;
  logic [23:0]     rgb;

  assign state_dbg = state;

  // A frame start with a pending/just-arrived step, or a hold expiry in RUN, advances the pattern.
  assign take = fsync && (pending || step ||
                          (state == ST_RUN && frame_cnt == FW'(HOLD_FRAMES - 1)));

  // Active-pixel position; active_d doubles as the previous-cycle active for edge detection.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (fsync) begin
      x       <= '0;
      y       <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (active_d && !active) begin
      x       <= '0;
      y       <= y + 1'b1;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (active) begin
      x <= x + 1'b1;
      if (bar_cnt == BW'(BAR_W - 1)) begin
        bar_cnt <= '0;
        bar_idx <= bar_idx + 1'b1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rgb = 24'h000000;
    if (active) begin
      case (pattern_id)
        3'd0: rgb = 24'hFF0000;
        3'd1: rgb = 24'h00FF00;
        3'd2: rgb = 24'h0000FF;
        3'd3: begin
          case (bar_idx)
            3'd0:    rgb = 24'hFFFFFF;
            3'd1:    rgb = 24'hFFFF00;
            3'd2:    rgb = 24'h00FFFF;
            3'd3:    rgb = 24'h00FF00;
            3'd4:    rgb = 24'hFF00FF;
            3'd5:    rgb = 24'hFF0000;
            3'd6:    rgb = 24'h0000FF;
            default: rgb = 24'h000000;
          endcase
        end
        3'd4:    rgb = (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
        default: rgb = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      pdata_r  <= '0;
      pdata_g  <= '0;
      pdata_b  <= '0;
      active_d <= 1'b0;
      hsync_d  <= 1'b0;
      vsync_d  <= 1'b0;
    end else begin
      {pdata_r, pdata_g, pdata_b} <= rgb;
      active_d <= active;
      hsync_d  <= hsync;
      vsync_d  <= vsync;
    end
  end

  // Scheduler: pattern_id only moves on the cycle after fsync, so frames never mix patterns.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      pattern_id  <= '0;
      frame_cnt   <= '0;
      pending     <= 1'b0;
      pattern_chg <= 1'b0;
    end else begin
      state       <= pause ? ST_PAUSED : ST_RUN;
      pattern_chg <= 1'b0;
      if (take) begin
        pattern_id  <= (pattern_id == 3'd4) ? 3'd0 : pattern_id + 3'd1;
        frame_cnt   <= '0;
        pending     <= 1'b0;
        pattern_chg <= 1'b1;
      end else begin
        if (fsync && state == ST_RUN) frame_cnt <= frame_cnt + 1'b1;
        if (step) pending <= 1'b1;
      end
    end
  end

endmodule
